// File: rtl/seq_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_div_pkg -- shared definitions for the sequential divider.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
// -----------------------------------------------------------------------------
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_div_pkg

// File: rtl/seq_div_if.sv
// -----------------------------------------------------------------------------
// seq_div_if -- request/response bundle of the sequential divider.
//   Start     : request, sampled on the rising clock edge
//   A, B      : dividend / divisor, sampled with Start
//   Signed    : two's-complement operands (only with SEQ_DIV_SIGNED_EN)
//   Busy      : division in progress
//   Done      : one-cycle pulse, Q/R/DivByZero valid
//   Q, R      : quotient / remainder
//   DivByZero : last accepted request had B == 0
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_div_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DivByZero;

`ifdef SEQ_DIV_SIGNED_EN
    logic             Signed;

    modport master (
        output Start, A, B, Signed,
        input  Busy, Done, Q, R, DivByZero
    );

    modport slave (
        input  Start, A, B, Signed,
        output Busy, Done, Q, R, DivByZero
    );
`else
    modport master (
        output Start, A, B,
        input  Busy, Done, Q, R, DivByZero
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, Q, R, DivByZero
    );
`endif

endinterface : seq_div_if

// File: rtl/seq_div_step.sv
// -----------------------------------------------------------------------------
// seq_div_step -- one radix-2 restoring division step (combinational).
//   rem_in  : partial remainder before the step (WIDTH+1 bits)
//   bit_in  : next dividend bit, MSB first
//   divisor : divisor magnitude
//   rem_out : partial remainder after shift / conditional subtract
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module seq_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem_in[WIDTH-1:0], bit_in};

    // A set top bit of rem_in means the shifted value is at least 2^(WIDTH+1),
    // which always exceeds the divisor; the modular subtraction below is still
    // exact in that case because the true difference fits in WIDTH+1 bits.
    assign q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule : seq_div_step

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- sequential radix-2 restoring divider, one quotient bit per cycle.
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : seq_div_if.slave (Start, A, B, [Signed], Busy, Done, Q, R,
//           DivByZero)
// A request is accepted in IDLE or DONE. A non-zero divisor spends WIDTH
// cycles in RUN and then one cycle in DONE; B == 0 goes straight to DONE with
// Q = all-ones, R = A. Q and R hold the last completed result.
// Optional feature: define SEQ_DIV_SIGNED_EN to add the Signed input
// (two's-complement operands, quotient truncated toward zero, remainder takes
// the sign of the dividend).
// -----------------------------------------------------------------------------
module seq_div
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic      Clk,
    input logic      Rst_n,
    seq_div_if.slave bus
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             q_neg_r, r_neg_r;
    logic [WIDTH-1:0] q_out, r_out;
    logic             dbz_r;

    logic             sgn, a_neg, b_neg, b_zero, accept, last_step;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_final, r_final;

`ifdef SEQ_DIV_SIGNED_EN
    assign sgn = bus.Signed;
`else
    assign sgn = 1'b0;
`endif

    // Operands are reduced to magnitudes up front; the most negative value
    // maps onto itself, which is its correct unsigned magnitude.
    assign a_neg  = sgn & bus.A[WIDTH-1];
    assign b_neg  = sgn & bus.B[WIDTH-1];
    assign a_mag  = a_neg ? -bus.A : bus.A;
    assign b_mag  = b_neg ? -bus.B : bus.B;
    assign b_zero = (bus.B == '0);

    // Start is ignored for the whole of RUN.
    assign accept    = bus.Start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == LAST);

    seq_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .bit_in  (quo_r[WIDTH-1]),
        .divisor (div_r),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign q_final = {quo_r[WIDTH-2:0], step_q};
    assign r_final = step_rem[WIDTH-1:0];

    // ---------------------------------------------------------------- FSM
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state takes a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (bus.Start) next_state = b_zero ? DONE : RUN;
                else           next_state = IDLE;
            end
            RUN: begin
                if (cnt == LAST) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            div_r   <= '0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            q_out   <= '0;
            r_out   <= '0;
            dbz_r   <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= a_mag;   // dividend shifts out MSB first, quotient in
            div_r   <= b_mag;
            q_neg_r <= a_neg ^ b_neg;
            r_neg_r <= a_neg;
            dbz_r   <= b_zero;
            if (b_zero) begin
                q_out <= '1;
                r_out <= bus.A;
            end
        end else if (state == RUN) begin
            cnt   <= cnt + 1'b1;
            rem_r <= step_rem;
            quo_r <= q_final;
            if (last_step) begin
                q_out <= q_neg_r ? -q_final : q_final;
                r_out <= r_neg_r ? -r_final : r_final;
            end
        end
    end

    assign bus.Busy      = (state == RUN);
    assign bus.Done      = (state == DONE);
    assign bus.Q         = q_out;
    assign bus.R         = r_out;
    assign bus.DivByZero = dbz_r;

endmodule : seq_div

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result bit width (>=2).
REQ-002 SHALL have port: Clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Start  input  1  request; sampled on Clk rise.
REQ-005 SHALL have port: A  input  WIDTH  dividend, sampled with Start.
REQ-006 SHALL have port: B  input  WIDTH  divisor, sampled with Start.
REQ-007 SHALL have port: Busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: Done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have port: Q  output  WIDTH  quotient.
REQ-010 SHALL have port: R  output  WIDTH  remainder.
REQ-011 SHALL have port: DivByZero  output  1  last accepted request had B==0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-013 SHALL accept Start in IDLE or DONE: latch A and B, clear DivByZero, go to RUN; if B==0, go to DONE instead.
REQ-014 SHALL ignore Start while in RUN (no relatch, no restart).
REQ-015 SHALL use radix-2 restoring division, MSB first, one quotient bit per cycle, WIDTH cycles in RUN.
REQ-016 SHALL keep a WIDTH+1-bit partial remainder internally so that no compare or subtract step overflows for any B.
REQ-017 SHALL assert Done WIDTH+1 rising edges after the edge sampling Start (B!=0), and 1 edge after (B==0).
REQ-018 SHALL hold Busy high exactly in RUN; Done SHALL be high exactly in DONE, for one cycle.
REQ-019 SHALL set Q=A/B and R=A%B on completion and hold both until the next accepted request completes.
REQ-020 SHALL, for B==0, set Q to all-ones, R=A and DivByZero=1, held until the next accepted Start.
REQ-021 SHALL return DONE->IDLE when Start is low, and DONE->RUN when Start is high (back-to-back operation).
REQ-022 SHALL leave Q and R unchanged while in RUN; they update only on entry to DONE.

Reset
REQ-023 SHALL, while Rst_n is low, force the state to IDLE and Busy, Done, DivByZero, Q and R to 0, regardless of Clk.
REQ-024 SHALL abort any division in progress when Rst_n is asserted mid-operation, with no Done pulse for it.
REQ-025 SHALL accept Start on the first rising edge after Rst_n deasserts.

Configuration
REQ-026 SHALL, when SEQ_DIV_SIGNED_EN is defined, add an input port Signed (1 bit, sampled with Start); Signed=1 means two's-complement operands.
REQ-027 SHALL, in signed mode, divide the magnitudes, truncate Q toward zero, and give R the sign of A; latency is unchanged.
REQ-028 SHALL, in signed mode with A=most-negative and B=-1, return Q=most-negative and R=0.
REQ-029 SHALL, in signed mode with B==0, return Q=all-ones, R=A and DivByZero=1.
REQ-030 SHALL, without SEQ_DIV_SIGNED_EN, omit the Signed port and operate unsigned only.

Structure
REQ-031 SHALL place the FSM state encoding constants (IDLE, RUN, DONE) in the shared package seq_div_pkg.
REQ-032 SHALL implement one restoring step (shift, compare, conditional subtract, quotient bit) as the combinational sub-module seq_div_step, instantiated once.

Verification
REQ-033 SHALL cover: WIDTH=16, Start with A=64, B=8 -> Done 17 edges later, Q=8, R=0, DivByZero=0.
REQ-034 SHALL cover: A=65, B=8 -> Q=8, R=1; then A=256, B=257 -> Q=0, R=256.
REQ-035 SHALL cover: A=1, B=0 -> Done 1 edge later, Q=16'hFFFF, R=1, DivByZero=1.
REQ-036 SHALL cover: A=65535, B=1, with Start pulsed again during RUN -> second Start ignored, Q=65535, R=0.
REQ-037 SHALL cover: Rst_n pulsed low at RUN cycle 5 -> no Done, outputs 0; next request A=100, B=7 -> Q=14, R=2.
REQ-038 SHALL cover, with SEQ_DIV_SIGNED_EN and Signed=1: A=-7, B=2 -> Q=-3, R=-1; A=16'h8000, B=-1 -> Q=16'h8000, R=0.
